// File: rtl/trace_core_pkg.sv
// Shared types and instruction-layout helpers for the trace replay core.
package trace_core_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_RSP,
    S_DELAY,
    S_DONE
  } state_e;

  // Width of the DELAY cycle count taken from the low data bits.
  localparam int DLY_W = 16;

  // Instruction layout is {op[1:0], addr[ADDR_W-1:0], data[DATA_W-1:0]}.
  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int op_lsb(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/trace_core_mem.sv
// Simple RAM: synchronous write port plus one read port that is either
// registered (1-cycle latency) or combinational, selected by ASYNC_RD.
module trace_core_mem #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter bit ASYNC_RD = 1'b0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are never cleared by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (ASYNC_RD) begin : g_async
      // Combinational read for host-side result inspection.
      always_comb rdata = mem[raddr];
    end else begin : g_sync
      // Registered read used for instruction fetch.
      always_ff @(posedge clk) rdata <= mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/trace_core_gen.sv
// Trace-driven processor core stand-in: replays READ/WRITE/DELAY/END
// instructions onto a valid/ready request port, one outstanding access.
module trace_core_gen
  import trace_core_pkg::*;
#(
  parameter int  ADDR_W  = 9,
  parameter int  DATA_W  = 32,
  parameter int  DEPTH   = 64,
  parameter int  CNT_W   = 16,
  localparam int PC_W    = $clog2(DEPTH),
  localparam int INSTR_W = 2 + ADDR_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               loop_en,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic               req_valid,
  output logic               req_write,
  output logic [ADDR_W-1:0]  req_addr,
  output logic [DATA_W-1:0]  req_wdata,
  input  logic               req_ready,
  input  logic               rsp_valid,
  input  logic [DATA_W-1:0]  rsp_rdata,
  input  logic [PC_W-1:0]    res_raddr,
  output logic [DATA_W-1:0]  res_rdata,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   rd_count,
  output logic [CNT_W-1:0]   wr_count
);

  localparam int OP_LSB   = op_lsb(ADDR_W, DATA_W);
  localparam int ADDR_LSB = addr_lsb(DATA_W);

  state_e             state, state_n;
  logic [PC_W-1:0]    pc, pc_n;
  logic [DLY_W-1:0]   dly_cnt, dly_n;
  logic               rv_n, rw_n;
  logic [ADDR_W-1:0]  ra_n;
  logic [DATA_W-1:0]  rd_n;
  logic [CNT_W-1:0]   rdc_n, wrc_n;
  logic               res_we;
  logic               trace_we;
  logic [INSTR_W-1:0] instr;
  op_e                ins_op;
  logic [ADDR_W-1:0]  ins_addr;
  logic [DATA_W-1:0]  ins_data;
  logic               at_last;
  state_e             end_state;

  assign ins_op    = op_e'(instr[OP_LSB +: 2]);
  assign ins_addr  = instr[ADDR_LSB +: ADDR_W];
  assign ins_data  = instr[DATA_W-1:0];
  assign at_last   = (pc == PC_W'(DEPTH - 1));
  assign end_state = loop_en ? S_FETCH : S_DONE;
  assign trace_we  = prog_we && (state == S_IDLE || state == S_DONE);
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);

  // The fetch address is the next-cycle pc so the registered read lands
  // exactly in the FETCH cycle.
  trace_core_mem #(
    .WIDTH    (INSTR_W),
    .DEPTH    (DEPTH),
    .ASYNC_RD (1'b0)
  ) u_trace (
    .clk   (clk),
    .we    (trace_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_n),
    .rdata (instr)
  );

  trace_core_mem #(
    .WIDTH    (DATA_W),
    .DEPTH    (DEPTH),
    .ASYNC_RD (1'b1)
  ) u_result (
    .clk   (clk),
    .we    (res_we),
    .waddr (pc),
    .wdata (rsp_rdata),
    .raddr (res_raddr),
    .rdata (res_rdata)
  );

  // State, pc, request fields and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= '0;
      dly_cnt   <= '0;
      req_valid <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      dly_cnt   <= dly_n;
      req_valid <= rv_n;
      req_write <= rw_n;
      req_addr  <= ra_n;
      req_wdata <= rd_n;
      rd_count  <= rdc_n;
      wr_count  <= wrc_n;
    end
  end

  // Next-state and next-register logic; advancing past the last entry is
  // treated exactly like an END instruction (pc wraps to 0 either way).
  always_comb begin
    state_n = state;
    pc_n    = pc;
    dly_n   = dly_cnt;
    rv_n    = req_valid;
    rw_n    = req_write;
    ra_n    = req_addr;
    rd_n    = req_wdata;
    rdc_n   = rd_count;
    wrc_n   = wr_count;
    res_we  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_n    = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        case (ins_op)
          OP_READ, OP_WRITE: begin
            rv_n    = 1'b1;
            rw_n    = (ins_op == OP_WRITE);
            ra_n    = ins_addr;
            rd_n    = ins_data;
            state_n = S_ISSUE;
          end
          OP_DELAY: begin
            if (ins_data[DLY_W-1:0] == '0) begin
              pc_n    = pc + 1'b1;
              state_n = at_last ? end_state : S_FETCH;
            end else begin
              dly_n   = ins_data[DLY_W-1:0];
              state_n = S_DELAY;
            end
          end
          default: begin
            pc_n    = '0;
            state_n = end_state;
          end
        endcase
      end
      S_ISSUE: begin
        if (req_ready) begin
          rv_n    = 1'b0;
          state_n = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (rsp_valid) begin
          if (req_write) begin
            if (wr_count != '1) wrc_n = wr_count + 1'b1;
          end else begin
            res_we = 1'b1;
            if (rd_count != '1) rdc_n = rd_count + 1'b1;
          end
          pc_n    = pc + 1'b1;
          state_n = at_last ? end_state : S_FETCH;
        end
      end
      S_DELAY: begin
        if (dly_cnt == DLY_W'(1)) begin
          pc_n    = pc + 1'b1;
          state_n = at_last ? end_state : S_FETCH;
        end else begin
          dly_n = dly_cnt - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trace_core_gen.sv
// Directed bench for trace_core_gen: vector table of single-access traces
// plus hand-written stall, delay, loop, reset and busy-write sequences.
module tb_trace_core_gen;
  import trace_core_pkg::*;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 64;
  localparam int CNT_W   = 16;
  localparam int PC_W    = 6;
  localparam int INSTR_W = 2 + ADDR_W + DATA_W;

  logic               clk;
  logic               reset;
  logic               start;
  logic               loop_en;
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               req_valid;
  logic               req_write;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic               req_ready;
  logic               rsp_valid;
  logic [DATA_W-1:0]  rsp_rdata;
  logic [PC_W-1:0]    res_raddr;
  logic [DATA_W-1:0]  res_rdata;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   rd_count;
  logic [CNT_W-1:0]   wr_count;

  trace_core_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .loop_en   (loop_en),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .res_raddr (res_raddr),
    .res_rdata (res_rdata),
    .busy      (busy),
    .done      (done),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Cycle counter and transfer log, observed on the falling edge.
  int               cyc = 0;
  logic             xfer_smp = 1'b0;
  int               nxfer = 0;
  int               last_rise = 0;
  logic             rv_prev = 1'b0;
  logic [ADDR_W-1:0] log_addr [64];
  logic             log_wr   [64];
  logic [DATA_W-1:0] log_data [64];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    xfer_smp = req_valid && req_ready;
    if (xfer_smp) begin
      log_addr[nxfer % 64] = req_addr;
      log_wr[nxfer % 64]   = req_write;
      log_data[nxfer % 64] = req_wdata;
      nxfer++;
    end
    if (req_valid && !rv_prev) last_rise = cyc;
    rv_prev = req_valid;
  end

  // Responder: rsp_valid is sampled two rising edges after each transfer.
  logic              rsp_auto;
  logic              rsp_force;
  logic [DATA_W-1:0] rsp_val;
  logic              rsp_fire = 1'b0;
  int                rsp_cnt = 0;

  always @(posedge clk) begin
    #1;
    rsp_fire = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) rsp_fire = 1'b1;
    end
    if (xfer_smp && rsp_auto) rsp_cnt = 1;
  end

  assign rsp_valid = rsp_fire || rsp_force;
  assign rsp_rdata = rsp_val;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int idx, input logic [1:0] op, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    prog_we   = 1'b1;
    prog_addr = PC_W'(idx);
    prog_data = {op, a, d};
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      if (done) break;
      tick();
    end
  endtask

  task automatic run();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
  endtask

  typedef struct {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] rsp;
    logic              exp_write;
    logic [DATA_W-1:0] exp_res;
  } vec_t;

  vec_t vecs [5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    int exp_rd;
    int exp_wr;
    int s0;
    int lat0;
    int lat1;
    logic [DATA_W-1:0] res0_exp;

    vecs[0] = '{OP_WRITE, 9'h005, 32'hDEADBEEF, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[1] = '{OP_READ,  9'h005, 32'h0000_0000, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{OP_WRITE, 9'h1FF, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[3] = '{OP_READ,  9'h000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
    vecs[4] = '{OP_READ,  9'h0AA, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h1234_5678};

    reset     = 1'b1;
    start     = 1'b0;
    loop_en   = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    req_ready = 1'b1;
    rsp_force = 1'b0;
    rsp_auto  = 1'b1;
    rsp_val   = '0;
    res_raddr = '0;
    exp_rd    = 0;
    exp_wr    = 0;
    res0_exp  = '0;

    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_write", req_write, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_wdata", req_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);

    // Write then read back the same address.
    prog(0, OP_WRITE, 9'h005, 32'hDEADBEEF);
    prog(1, OP_READ,  9'h005, 32'h0);
    prog(2, OP_END,   9'h000, 32'h0);
    rsp_val = 32'hDEADBEEF;
    base = nxfer;
    run();
    chk("wr_rd_done", done, 1);
    chk("wr_rd_busy", busy, 0);
    chk("wr_rd_nxfer", nxfer - base, 2);
    chk("wr_rd_x0_write", log_wr[base % 64], 1);
    chk("wr_rd_x0_addr", log_addr[base % 64], 9'h005);
    chk("wr_rd_x0_data", log_data[base % 64], 32'hDEADBEEF);
    chk("wr_rd_x1_write", log_wr[(base + 1) % 64], 0);
    chk("wr_rd_x1_addr", log_addr[(base + 1) % 64], 9'h005);
    res_raddr = 6'd1;
    #1;
    chk("wr_rd_result1", res_rdata, 32'hDEADBEEF);
    exp_wr++;
    exp_rd++;
    chk("wr_rd_wr_count", wr_count, 64'(exp_wr));
    chk("wr_rd_rd_count", rd_count, 64'(exp_rd));

    // Vector table: one access followed by END.
    for (int v = 0; v < 5; v++) begin
      prog(0, vecs[v].op, vecs[v].addr, vecs[v].data);
      prog(1, OP_END, 9'h000, 32'h0);
      rsp_val = vecs[v].rsp;
      base = nxfer;
      run();
      chk($sformatf("vec%0d_done", v), done, 1);
      chk($sformatf("vec%0d_nxfer", v), nxfer - base, 1);
      chk($sformatf("vec%0d_write", v), log_wr[base % 64], vecs[v].exp_write);
      chk($sformatf("vec%0d_addr", v), log_addr[base % 64], vecs[v].addr);
      if (vecs[v].exp_write) begin
        chk($sformatf("vec%0d_wdata", v), log_data[base % 64], vecs[v].data);
        exp_wr++;
      end else begin
        res_raddr = 6'd0;
        #1;
        chk($sformatf("vec%0d_result", v), res_rdata, vecs[v].exp_res);
        res0_exp = vecs[v].exp_res;
        exp_rd++;
      end
      chk($sformatf("vec%0d_rd_count", v), rd_count, 64'(exp_rd));
      chk($sformatf("vec%0d_wr_count", v), wr_count, 64'(exp_wr));
    end

    // Backpressure: request held stable for five stalled cycles.
    prog(0, OP_WRITE, 9'h033, 32'hCAFEF00D);
    prog(1, OP_END,   9'h000, 32'h0);
    req_ready = 1'b0;
    base = nxfer;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_valid) break;
      tick();
    end
    chk("stall_valid_seen", req_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k), req_valid, 1);
      chk($sformatf("stall%0d_addr", k), req_addr, 9'h033);
      chk($sformatf("stall%0d_wdata", k), req_wdata, 32'hCAFEF00D);
      tick();
    end
    chk("stall_no_xfer", nxfer - base, 0);
    req_ready = 1'b1;
    wait_done();
    exp_wr++;
    chk("stall_done", done, 1);
    chk("stall_nxfer", nxfer - base, 1);
    chk("stall_wr_count", wr_count, 64'(exp_wr));

    // DELAY 4 dwells four cycles, plus one FETCH for the following READ.
    prog(0, OP_READ, 9'h010, 32'h0);
    prog(1, OP_END,  9'h000, 32'h0);
    rsp_val = 32'hA5A5_0001;
    start = 1'b1;
    s0 = cyc;
    tick();
    start = 1'b0;
    wait_done();
    lat0 = last_rise - s0;
    res0_exp = 32'hA5A5_0001;
    prog(0, OP_DELAY, 9'h000, 32'd4);
    prog(1, OP_READ,  9'h010, 32'h0);
    prog(2, OP_END,   9'h000, 32'h0);
    start = 1'b1;
    s0 = cyc;
    tick();
    start = 1'b0;
    wait_done();
    lat1 = last_rise - s0;
    exp_rd += 2;
    chk("delay_lat_base", lat0, 2);
    chk("delay_offset", lat1 - lat0, 5);
    chk("delay_done", done, 1);
    chk("delay_rd_count", rd_count, 64'(exp_rd));

    // Loop three times, drop loop_en while the END is being fetched.
    prog(0, OP_READ, 9'h001, 32'h0);
    prog(1, OP_END,  9'h000, 32'h0);
    rsp_val = 32'h0000_1111;
    loop_en = 1'b1;
    base = nxfer;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rd_count == CNT_W'(exp_rd + 3)) break;
      tick();
    end
    loop_en = 1'b0;
    wait_done();
    exp_rd += 3;
    res0_exp = 32'h0000_1111;
    chk("loop_done", done, 1);
    chk("loop_nxfer", nxfer - base, 3);
    chk("loop_rd_count", rd_count, 64'(exp_rd));

    // Reset while waiting for a response; the late response is ignored.
    rsp_auto = 1'b0;
    prog(0, OP_READ, 9'h044, 32'h0);
    prog(1, OP_END,  9'h000, 32'h0);
    base = nxfer;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (nxfer > base) break;
    end
    chk("rstmid_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("rstmid_async_valid", req_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rsp_val = 32'h5555_5555;
    rsp_force = 1'b1;
    tick();
    rsp_force = 1'b0;
    tick();
    exp_rd = 0;
    exp_wr = 0;
    res_raddr = 6'd0;
    #1;
    chk("rstmid_req_valid", req_valid, 0);
    chk("rstmid_req_addr", req_addr, 0);
    chk("rstmid_req_write", req_write, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_rd_count", rd_count, 0);
    chk("rstmid_wr_count", wr_count, 0);
    chk("rstmid_result0", res_rdata, res0_exp);
    rsp_auto = 1'b1;

    // Program write and start while busy are both ignored.
    prog(0, OP_READ, 9'h020, 32'h0);
    prog(1, OP_READ, 9'h021, 32'h0);
    prog(2, OP_END,  9'h000, 32'h0);
    rsp_val = 32'h0BAD_F00D;
    base = nxfer;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    prog_we   = 1'b1;
    prog_addr = 6'd1;
    prog_data = {OP_END, 9'h000, 32'h0};
    start     = 1'b1;
    tick();
    prog_we = 1'b0;
    start   = 1'b0;
    wait_done();
    exp_rd += 2;
    chk("busyprog_done", done, 1);
    chk("busyprog_nxfer", nxfer - base, 2);
    chk("busyprog_addr0", log_addr[base % 64], 9'h020);
    chk("busyprog_addr1", log_addr[(base + 1) % 64], 9'h021);
    chk("busyprog_rd_count", rd_count, 64'(exp_rd));
    base = nxfer;
    run();
    exp_rd += 2;
    chk("rerun_nxfer", nxfer - base, 2);
    chk("rerun_addr1", log_addr[(base + 1) % 64], 9'h021);
    chk("rerun_rd_count", rd_count, 64'(exp_rd));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
